// File: rtl/power2round_unit.sv
// Power2Round stage of the keygen datapath.
//
// Reads the 256 INTT result coefficients r through a read-only RAM port and
// splits each into t1 = (r + 2^(D-1) - 1) >> D and t0 = r - t1 * 2^D.
// Results stream out in index order over a valid/ready handshake. A 2-entry
// output FIFO with credit-based read issue absorbs backpressure.
//
// Optional feature: define P2R_RANGE_CHECK_EN to build the sticky range_err
// flag (set when a captured r >= Q). Without it range_err is tied low.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           level request, sampled only in IDLE
//   done            high in DONE until start drops
//   ram_addr        registered RAM read address
//   ram_rdata       RAM read data, valid the cycle after ram_addr is issued
//   out_valid/out_ready  output handshake
//   out_idx, out_t1, out_t0, out_last  output beat (t0 two's complement)
//   range_err       sticky out-of-range flag
`timescale 1ns/1ps
module power2round_unit #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned D     = 13,
  parameter int unsigned Q     = 8380417
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 done,
  output logic [7:0]           ram_addr,
  input  logic [WIDTH-1:0]     ram_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_idx,
  output logic [WIDTH-D-2:0]   out_t1,
  output logic [D:0]           out_t0,
  output logic                 out_last,
  output logic                 range_err
);

  localparam int unsigned T1W   = WIDTH - D - 1;
  localparam int unsigned T0W   = D + 1;
  // Adding 2^(D-1)-1 before the shift centres t0 in (-2^(D-1), 2^(D-1)].
  localparam int unsigned Round = (1 << (D - 1)) - 1;

  if ((Q >> WIDTH) != 0) begin : g_q_check
    $error("Q must fit in WIDTH bits");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [8:0]       rd_cnt_q;
  logic             inflight_q;
  logic [7:0]       ram_addr_q;
  logic [1:0]       count_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [7:0]       idx_q  [2];
  logic [T1W-1:0]   t1_q   [2];
  logic [T0W-1:0]   t0_q   [2];
  logic             last_q [2];

  logic             clear, issue, push, pop;
  logic [2:0]       credit;
  logic [WIDTH:0]   sum;
  logic [T1W-1:0]   cap_t1;
  logic [T0W-1:0]   cap_t0;

  // Combinational conversion of the word arriving this cycle.
  always_comb begin
    sum    = {1'b0, ram_rdata} + Round[WIDTH:0];
    cap_t1 = T1W'(sum >> D);
    cap_t0 = T0W'(ram_rdata - (WIDTH'(cap_t1) << D));
  end

  always_comb begin
    clear  = (state_q == StIdle) && start;
    push   = inflight_q;
    pop    = (count_q != 2'd0) && out_ready;
    // The pop of this cycle frees a slot in time for the read issued now,
    // which keeps full throughput while never exceeding two entries.
    credit = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue  = (state_q == StRun) && !rd_cnt_q[8] && (credit < 3'd2);

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (pop && out_last) state_d = StDone;
      StDone:  if (!start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rd_cnt_q   <= '0;
      inflight_q <= 1'b0;
      ram_addr_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        rd_cnt_q   <= '0;
        inflight_q <= 1'b0;
        count_q    <= '0;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
      end else begin
        inflight_q <= issue;
        if (issue) begin
          ram_addr_q <= rd_cnt_q[7:0];
          rd_cnt_q   <= rd_cnt_q + 9'd1;
        end
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // FIFO storage; the captured index is the address that produced the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        idx_q[i]  <= '0;
        t1_q[i]   <= '0;
        t0_q[i]   <= '0;
        last_q[i] <= 1'b0;
      end
    end else if (push) begin
      idx_q[wr_ptr_q]  <= ram_addr_q;
      t1_q[wr_ptr_q]   <= cap_t1;
      t0_q[wr_ptr_q]   <= cap_t0;
      last_q[wr_ptr_q] <= (ram_addr_q == 8'd255);
    end
  end

  always_comb begin
    done      = (state_q == StDone);
    ram_addr  = ram_addr_q;
    out_valid = (count_q != 2'd0);
    out_idx   = idx_q[rd_ptr_q];
    out_t1    = t1_q[rd_ptr_q];
    out_t0    = t0_q[rd_ptr_q];
    out_last  = last_q[rd_ptr_q];
  end

`ifdef P2R_RANGE_CHECK_EN
  logic range_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err_q <= 1'b0;
    end else if (clear) begin
      range_err_q <= 1'b0;
    end else if (push && (ram_rdata >= Q[WIDTH-1:0])) begin
      range_err_q <= 1'b1;
    end
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_power2round_unit.sv
`timescale 1ns/1ps
module tb_power2round_unit;

`ifdef P2R_RANGE_CHECK_EN
  localparam bit RangeOn = 1'b1;
`else
  localparam bit RangeOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        done, out_valid, out_last, range_err;
  logic [7:0]  ram_addr, out_idx;
  logic [23:0] ram_rdata;
  logic [9:0]  out_t1;
  logic [13:0] out_t0;

  logic [23:0] mem [256];
  assign ram_rdata = mem[ram_addr];

  always #5 clk = ~clk;

  power2round_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_t1    (out_t1),
    .out_t0    (out_t0),
    .out_last  (out_last),
    .range_err (range_err)
  );

  typedef struct {
    logic [7:0] idx;
    int         t1;
    int         t0;
    bit         last;
    bit         dc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   beats = 0;
  int   first_cyc = -1;
  int   last_cyc = -1;
  bit   range_test = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: pops one expectation per accepted beat.
  initial begin : monitor
    logic [32:0] held;
    bit          stall;
    exp_t        e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall && out_valid)
          check("stall_hold", {out_idx, out_t1, out_t0, out_last}, held);
        stall = out_valid && !out_ready;
        held  = {out_idx, out_t1, out_t0, out_last};
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got idx %0d expected no beat", out_idx);
          end else begin
            e = exp_q.pop_front();
            check("idx", out_idx, e.idx);
            check("last", out_last, e.last);
            if (!e.dc) begin
              check("t1", out_t1, e.t1);
              check("t0", longint'($signed(out_t0)), e.t0);
            end
          end
          beats++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
        end
      end
    end
  end

  // Hand-derived patterns: r = i*32768 + k gives t1 = 4i + (k+4095)/8192.
  task automatic load(input int pat);
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      e.idx  = 8'(i);
      e.last = (i == 255);
      e.dc   = 1'b0;
      case (pat)
        0:       begin mem[i] = 24'(i * 32768);        e.t1 = 4 * i;     e.t0 = 0;     end
        1:       begin mem[i] = 24'(i * 32768 + 4096); e.t1 = 4 * i;     e.t0 = 4096;  end
        2:       begin mem[i] = 24'(i * 32768 + 4097); e.t1 = 4 * i + 1; e.t0 = -4095; end
        default: begin mem[i] = 24'(i * 32768 + 8191); e.t1 = 4 * i + 1; e.t0 = -1;    end
      endcase
      exp_q.push_back(e);
    end
  endtask

  // Call at posedge+#1; returns at the negedge where done is first seen.
  task automatic run(input bit toggle, input bit hold, input int abort_at,
                     output int done_cyc);
    beats     = 0;
    first_cyc = -1;
    last_cyc  = -1;
    done_cyc  = -1;
    cyc       = 0;
    start     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if (cyc == 1) check("range_err_cleared", range_err, 0);
      if (range_test && cyc == 19) check("range_err_before", range_err, 0);
      if (range_test && cyc == 20) check("range_err_rise", range_err, RangeOn);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!hold) start = 1'b0;
      out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("valid_in_reset", out_valid, 0);
        check("done_in_reset", done, 0);
        exp_q.delete();
        return;
      end
    end
    check("done_seen", done_cyc >= 0, 1);
  endtask

  task automatic check_full_rate(input int done_cyc);
    check("done_cycle", done_cyc, 259);
    check("first_beat_cycle", first_cyc, 3);
    check("last_beat_cycle", last_cyc, 258);
    check("beat_count", beats, 256);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #400us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int dc;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_t1", out_t1, 0);
    check("rst_out_t0", out_t0, 0);
    check("rst_out_last", out_last, 0);
    check("rst_range_err", range_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed edge values at idx 0..3
    load(0);
    mem[0] = 24'd0;       exp_q[0].t1 = 0;    exp_q[0].t0 = 0;
    mem[1] = 24'd4096;    exp_q[1].t1 = 0;    exp_q[1].t0 = 4096;
    mem[2] = 24'd4097;    exp_q[2].t1 = 1;    exp_q[2].t0 = -4095;
    mem[3] = 24'd8380416; exp_q[3].t1 = 1023; exp_q[3].t0 = 0;
    run(1'b0, 1'b0, -1, dc);
    check_full_rate(dc);
    @(posedge clk);
    #1;

    // Out-of-range word at idx 17
    load(1);
    mem[17] = 24'd8380417;
    exp_q[17].dc = 1'b1;
    range_test = 1'b1;
    run(1'b0, 1'b0, -1, dc);
    range_test = 1'b0;
    check_full_rate(dc);
    check("range_err_sticky", range_err, RangeOn);
    @(posedge clk);
    #1;

    // Backpressure, 1-on/2-off ready
    load(2);
    run(1'b1, 1'b0, -1, dc);
    check("bp_beat_count", beats, 256);
    check("bp_queue_drained", exp_q.size(), 0);
    check("bp_done_after_last", dc > last_cyc, 1);
    @(posedge clk);
    #1;

    // Reset mid-stream while idx 100 is presented
    load(2);
    run(1'b0, 1'b0, 103, dc);
    check("abort_beats", beats, 100);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load(0);
    run(1'b0, 1'b0, -1, dc);
    check_full_rate(dc);
    @(posedge clk);
    #1;

    // start held after DONE: no restart until start drops
    load(3);
    run(1'b0, 1'b1, -1, dc);
    check_full_rate(dc);
    repeat (10) begin
      @(negedge clk);
      check("hold_done", done, 1);
      check("hold_no_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("done_drop", done, 0);
    load(3);
    run(1'b0, 1'b0, -1, dc);
    check_full_rate(dc);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
